// File: rtl/bf_uart_tx.sv
// Buffered 8N1 UART transmitter. Bytes queue in a small FIFO and are sent
// LSB-first. The shift/baud FSM state is exported on dbgState.
`timescale 1ns/1ps
module bf_uart_tx #(
  parameter int CLKS_PER_BIT = 100,
  parameter int DEPTH_LOG    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           tx_data,
  input  logic                 tx_send,
  output logic                 tx_busy,
  input  logic                 block,
  output logic                 tx,
  output logic [DEPTH_LOG:0]   level,
  output logic                 overflow,
  output logic [1:0]           dbgState
);

  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG:0] FULL_LVL = (DEPTH_LOG + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [CNT_W-1:0]     baudCnt;
  logic [2:0]           bitIdx;
  logic [7:0]           shift;
  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0] head;
  logic [DEPTH_LOG-1:0] tail;
  logic                 bitEnd;
  logic                 canStart;
  logic                 push;
  logic                 pop;

  // Handshake: a write is taken on any edge with tx_send=1 and tx_busy=0;
  // tx_busy comes straight from the registered level, so a pop on the same
  // edge never makes room for a write presented while full.
  assign tx_busy  = (level == FULL_LVL);
  assign bitEnd   = (baudCnt == CNT_LAST);
  assign canStart = (level != '0) && !block;
  assign push     = tx_send && !tx_busy;
  assign pop      = canStart && ((state == IDLE) || ((state == STOP) && bitEnd));
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[tail] <= tx_data;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (tx_send && tx_busy) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // tx is loaded with the value of the state being entered, so each bit
  // appears on the line on the same edge the state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baudCnt <= '0;
      bitIdx  <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          baudCnt <= '0;
          if (pop) begin
            shift <= mem[head];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            baudCnt <= '0;
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bitIdx  <= '0;
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx     <= shift[0];
              shift  <= {1'b0, shift[7:1]};
              bitIdx <= bitIdx + 1'b1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (pop) begin
              shift <= mem[head];
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Bench for bf_uart_tx: serial monitor decodes frames and compares them
// against an expected-byte queue filled as writes are driven.
`timescale 1ns/1ps
module tb_bf_uart_tx;

  localparam int CPB = 4;
  localparam int DL  = 2;
  localparam int FRAME = 10 * CPB;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   tx_data;
  logic         tx_send;
  logic         tx_busy;
  logic         block;
  logic         tx;
  logic [DL:0]  level;
  logic         overflow;
  logic [1:0]   dbgState;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         total = 0;
  int         bad = 0;
  int         frames = 0;
  int         cyc = 0;
  int         rst_count = 0;

  bf_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH_LOG(DL)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_send(tx_send),
    .tx_busy(tx_busy), .block(block), .tx(tx), .level(level),
    .overflow(overflow), .dbgState(dbgState)
  );

  // clock / reset bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    if (rst) rst_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks: called at a negedge, return at the next negedge
  task automatic drive_write(input logic [7:0] b, input bit expect_sent);
    tx_send = 1'b1;
    tx_data = b;
    if (expect_sent) exp_q.push_back(b);
    @(negedge clk);
    tx_send = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_queue_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // serial monitor / scoreboard: samples each bit mid-cell
  initial begin : monitor
    logic [7:0] rx;
    int         rc;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        rc = rst_count;
        aborted = 1'b0;
        start_q.push_back(cyc);
        repeat (2) @(negedge clk);
        if (rst_count != rc) aborted = 1'b1;
        else check_eq("start_bit", tx, 0);
        for (int i = 0; i < 8 && !aborted; i++) begin
          repeat (CPB) @(negedge clk);
          if (rst_count != rc) aborted = 1'b1;
          rx[i] = tx;
        end
        if (!aborted) begin
          repeat (CPB) @(negedge clk);
          if (rst_count != rc) aborted = 1'b1;
        end
        if (!aborted) begin
          check_eq("stop_bit", tx, 1);
          frames++;
          if (exp_q.size() == 0) check_eq("rx_unexpected", {24'b0, rx}, 32'hFFFF_FFFF);
          else check_eq("rx_byte", rx, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] pat;
    int f0;
    rst = 1'b1;
    tx_send = 1'b0;
    tx_data = '0;
    block = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_state", dbgState, 0);
    repeat (2) @(negedge clk);

    // single byte with exact waveform
    pat = 8'h41;
    drive_write(pat, 1'b1);
    check_eq("single_level_after_write", level, 1);
    check_eq("single_tx_before_start", tx, 1);
    @(negedge clk);
    check_eq("single_level_after_pop", level, 0);
    for (int k = 0; k < FRAME; k++) begin
      if (k < CPB) check_eq("single_wave", tx, 0);
      else if (k < 9 * CPB) check_eq("single_wave", tx, pat[(k - CPB) / CPB]);
      else check_eq("single_wave", tx, 1);
      @(negedge clk);
    end
    check_eq("single_idle_tx", tx, 1);
    check_eq("single_idle_state", dbgState, 0);
    check_eq("single_frames", frames, 1);
    check_eq("single_queue", exp_q.size(), 0);

    // burst of five, back-to-back frames
    start_q.delete();
    f0 = frames;
    for (int i = 1; i <= 5; i++) begin
      drive_write(8'(i), 1'b1);
      if (i == 3) check_eq("burst_busy_low_3", tx_busy, 0);
    end
    check_eq("burst_level_full", level, 4);
    check_eq("burst_busy_full", tx_busy, 1);
    wait_drain(6 * FRAME);
    check_eq("burst_frames", frames - f0, 5);
    check_eq("burst_overflow", overflow, 0);
    check_eq("burst_starts", start_q.size(), 5);
    for (int i = 0; i + 1 < start_q.size(); i++)
      check_eq("burst_period", start_q[i+1] - start_q[i], FRAME);
    if (start_q.size() == 5)
      check_eq("burst_total_cycles", start_q[4] + FRAME - start_q[0], 200);

    // overflow while blocked
    block = 1'b1;
    f0 = frames;
    for (int i = 0; i < 5; i++) begin
      drive_write(8'hA0 + 8'(i), i < 4);
      if (i == 3) check_eq("ovf_busy_after_4", tx_busy, 1);
    end
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_level", level, 4);
    check_eq("ovf_no_frame_while_blocked", frames - f0, 0);
    block = 1'b0;
    wait_drain(6 * FRAME);
    repeat (FRAME + 10) @(negedge clk);
    check_eq("ovf_frames", frames - f0, 4);
    check_eq("ovf_sticky", overflow, 1);

    // block raised mid-frame
    f0 = frames;
    drive_write(8'h55, 1'b1);
    drive_write(8'h66, 1'b1);
    drive_write(8'h77, 1'b1);
    repeat (10) @(negedge clk);
    check_eq("blk_in_data", dbgState, 2);
    block = 1'b1;
    repeat (FRAME) @(negedge clk);
    check_eq("blk_tx_idle", tx, 1);
    check_eq("blk_level", level, 2);
    check_eq("blk_state", dbgState, 0);
    check_eq("blk_frames", frames - f0, 1);
    block = 1'b0;
    wait_drain(4 * FRAME);
    check_eq("blk_frames_after", frames - f0, 3);

    // push and pop on the same edge at a frame boundary
    drive_write(8'hC1, 1'b1);
    drive_write(8'hC2, 1'b1);
    check_eq("pp_level_before", level, 1);
    repeat (FRAME - 1) @(negedge clk);
    drive_write(8'hC3, 1'b1);
    check_eq("pp_level_same", level, 1);
    check_eq("pp_new_start", tx, 0);
    wait_drain(4 * FRAME);

    // reset during bit 3
    f0 = frames;
    drive_write(8'h3C, 1'b1);
    drive_write(8'h99, 1'b1);
    repeat (4 * CPB - 1) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstmid_tx", tx, 1);
    check_eq("rstmid_level", level, 0);
    check_eq("rstmid_overflow", overflow, 0);
    check_eq("rstmid_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    drive_write(8'h0A, 1'b1);
    wait_drain(2 * FRAME);
    repeat (FRAME) @(negedge clk);
    check_eq("rstmid_frames", frames - f0, 1);
    check_eq("final_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
